// File: rtl/mandel_job_sched.sv
// Raster job dispatcher for two Mandelbrot cores, with round-robin result write-back.
// Defining MANDEL_SCHED_PERF_EN adds a saturating frame-duration cycle counter.
module mandel_job_sched #(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iStart,
    output logic        oBusy,
    output logic        oDone,
    output logic [9:0]  oJob_X,
    output logic [9:0]  oJob_Y,
    output logic [1:0]  oJob_Valid,
    input  logic [1:0]  iJob_Ready,
    input  logic [1:0]  iRes_Valid,
    input  logic [9:0]  iRes_X0,
    input  logic [9:0]  iRes_Y0,
    input  logic [7:0]  iRes_Cnt0,
    input  logic [9:0]  iRes_X1,
    input  logic [9:0]  iRes_Y1,
    input  logic [7:0]  iRes_Cnt1,
    output logic [1:0]  oRes_Ready,
    output logic [18:0] oFB_Addr,
    output logic [7:0]  oFB_Data,
    output logic        oFB_WE,
    output logic [23:0] oFrame_Cycles
);

    localparam int unsigned COORD_W = 10;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned OUT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [COORD_W-1:0] x_q, y_q;
    logic [OUT_W-1:0]   outst_q;
    logic               job_ptr_q, res_ptr_q;
    logic               fb_we_q;
    logic [ADDR_W-1:0]  fb_addr_q;
    logic [CNT_W-1:0]   fb_data_q;
    logic               busy_q, done_q;

    logic               job_pending_c, res_open_c;
    logic [1:0]         job_grant_c, res_grant_c;
    logic               job_hs_c, res_hs_c, last_pix_c, frame_start_c;
    logic [COORD_W-1:0] res_x_c, res_y_c;
    logic [CNT_W-1:0]   res_cnt_c;
    logic [ADDR_W-1:0]  res_addr_c;

    // Two-requester round-robin: on contention the pointer picks, otherwise the lone requester wins.
    function automatic logic [1:0] rr_grant(input logic [1:0] req, input logic ptr);
        logic [1:0] g;
        if (req == 2'b11) begin
            g = ptr ? 2'b10 : 2'b01;
        end else begin
            g = req;
        end
        return g;
    endfunction

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the combinational job/result handshake signals.
    always_comb begin
        state_next    = state;
        job_pending_c = 1'b0;
        res_open_c    = 1'b0;
        job_grant_c   = rr_grant(iJob_Ready, job_ptr_q);
        res_grant_c   = rr_grant(iRes_Valid, res_ptr_q);
        oJob_Valid    = 2'b00;
        oRes_Ready    = 2'b00;
        frame_start_c = (state == ST_IDLE) && iStart;
        last_pix_c    = (x_q == COORD_W'(H_RES - 1)) && (y_q == COORD_W'(V_RES - 1));

        if (state == ST_SCAN) begin
            job_pending_c = (outst_q < OUT_W'(MAX_OUT));
        end
        if ((state == ST_SCAN) || (state == ST_DRAIN)) begin
            res_open_c = 1'b1;
        end

        if (job_pending_c) begin
            oJob_Valid = job_grant_c;
        end
        if (res_open_c) begin
            oRes_Ready = res_grant_c;
        end
        job_hs_c = |oJob_Valid;
        res_hs_c = |oRes_Ready;

        res_x_c    = oRes_Ready[1] ? iRes_X1   : iRes_X0;
        res_y_c    = oRes_Ready[1] ? iRes_Y1   : iRes_Y0;
        res_cnt_c  = oRes_Ready[1] ? iRes_Cnt1 : iRes_Cnt0;
        res_addr_c = ADDR_W'(res_y_c) * ADDR_W'(H_RES) + ADDR_W'(res_x_c);

        case (state)
            ST_IDLE: begin
                if (iStart) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (job_hs_c && last_pix_c) begin
                    state_next = ST_DRAIN;
                end
            end
            // Wait until every job has returned and the final write has left the register.
            ST_DRAIN: begin
                if ((outst_q == '0) && !fb_we_q) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            x_q       <= '0;
            y_q       <= '0;
            outst_q   <= '0;
            job_ptr_q <= 1'b0;
            res_ptr_q <= 1'b0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            busy_q  <= (state_next == ST_SCAN) || (state_next == ST_DRAIN);
            done_q  <= (state_next == ST_DONE);
            fb_we_q <= res_hs_c;
            if (res_hs_c) begin
                fb_addr_q <= res_addr_c;
                fb_data_q <= res_cnt_c;
                res_ptr_q <= oRes_Ready[0];
            end

            if (frame_start_c) begin
                x_q     <= '0;
                y_q     <= '0;
                outst_q <= '0;
            end else begin
                if (job_hs_c) begin
                    job_ptr_q <= oJob_Valid[0];
                    if (x_q == COORD_W'(H_RES - 1)) begin
                        x_q <= '0;
                        y_q <= last_pix_c ? '0 : y_q + COORD_W'(1);
                    end else begin
                        x_q <= x_q + COORD_W'(1);
                    end
                end
                // A job and a result in the same cycle cancel out.
                if (job_hs_c && !res_hs_c) begin
                    outst_q <= outst_q + OUT_W'(1);
                end else if (!job_hs_c && res_hs_c) begin
                    outst_q <= outst_q - OUT_W'(1);
                end
            end
        end
    end

    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oJob_X   = x_q;
    assign oJob_Y   = y_q;
    assign oFB_WE   = fb_we_q;
    assign oFB_Addr = fb_addr_q;
    assign oFB_Data = fb_data_q;

`ifdef MANDEL_SCHED_PERF_EN
    localparam int unsigned PERF_W = 24;

    logic [PERF_W-1:0] perf_q;

    // Frame duration: cleared on start, counts SCAN/DRAIN cycles, holds until the next start.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            perf_q <= '0;
        end else if (frame_start_c) begin
            perf_q <= '0;
        end else if (((state == ST_SCAN) || (state == ST_DRAIN)) && (perf_q != '1)) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    assign oFrame_Cycles = perf_q;
`else
    assign oFrame_Cycles = '0;
`endif

endmodule

// File: tb/tb_mandel_job_sched.sv
// Randomized bench for mandel_job_sched: bench-side core models plus a raster/round-robin reference.
`timescale 1ns/1ps
module tb_mandel_job_sched;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int MO   = 2;
    localparam int NPIX = H * V;

    typedef struct {
        int x;
        int y;
        int due;
    } job_t;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iStart;
    logic        oBusy, oDone;
    logic [9:0]  oJob_X, oJob_Y;
    logic [1:0]  oJob_Valid, iJob_Ready, iRes_Valid, oRes_Ready;
    logic [9:0]  iRes_X0, iRes_Y0, iRes_X1, iRes_Y1;
    logic [7:0]  iRes_Cnt0, iRes_Cnt1;
    logic [18:0] oFB_Addr;
    logic [7:0]  oFB_Data;
    logic        oFB_WE;
    logic [23:0] oFrame_Cycles;

    mandel_job_sched #(.H_RES(H), .V_RES(V), .MAX_OUT(MO)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .oBusy(oBusy), .oDone(oDone),
        .oJob_X(oJob_X), .oJob_Y(oJob_Y), .oJob_Valid(oJob_Valid), .iJob_Ready(iJob_Ready),
        .iRes_Valid(iRes_Valid), .iRes_X0(iRes_X0), .iRes_Y0(iRes_Y0), .iRes_Cnt0(iRes_Cnt0),
        .iRes_X1(iRes_X1), .iRes_Y1(iRes_Y1), .iRes_Cnt1(iRes_Cnt1), .oRes_Ready(oRes_Ready),
        .oFB_Addr(oFB_Addr), .oFB_Data(oFB_Data), .oFB_WE(oFB_WE), .oFrame_Cycles(oFrame_Cycles)
    );

    always #5 iCLK = ~iCLK;

    job_t q0[$];
    job_t q1[$];
    int   cyc, phase, done_at, next_pix, outst, nres, job_fav, res_fav, salt;
    int   rmode, lmin, lmax, busy_cycles, done_seen;
    int   jobs_k[2];
    bit   exp_we;
    int   exp_addr, exp_data;
    bit   written[NPIX];
    int   vectors, miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] cnt_of(input int x, input int y);
        return 8'(x * 29 + y * 53 + salt);
    endfunction

    function automatic logic [1:0] rr_pick(input logic [1:0] req, input int fav);
        if (req == 2'b11) return (fav == 0) ? 2'b01 : 2'b10;
        return req;
    endfunction

    task automatic model_reset();
        phase = 0; outst = 0; job_fav = 0; res_fav = 0; exp_we = 0;
        next_pix = 0; nres = 0; done_at = -1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_job_valid", oJob_Valid, 0);
        chk("rst_res_ready", oRes_Ready, 0);
        chk("rst_fb_we", oFB_WE, 0);
        chk("rst_done", oDone, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_job_x", oJob_X, 0);
        chk("rst_job_y", oJob_Y, 0);
        chk("rst_fb_addr", oFB_Addr, 0);
        chk("rst_fb_data", oFB_Data, 0);
        chk("rst_frame_cycles", oFrame_Cycles, 0);
    endtask

    // One clock: drive cores, check every output against the reference, advance the reference.
    task automatic step(input bit start);
        logic [1:0] jr, rv, ejv, err;
        bit   busy_e, done_e;
        int   k;
        job_t j;
        @(negedge iCLK);
        case (rmode)
            0:       jr = 2'b11;
            1:       jr = 2'b01;
            default: jr = 2'($urandom_range(0, 3));
        endcase
        rv[0] = (q0.size() > 0) && (q0[0].due <= cyc);
        rv[1] = (q1.size() > 0) && (q1[0].due <= cyc);
        if (rv[0]) begin
            iRes_X0 = 10'(q0[0].x); iRes_Y0 = 10'(q0[0].y); iRes_Cnt0 = cnt_of(q0[0].x, q0[0].y);
        end else begin
            iRes_X0 = 10'($urandom); iRes_Y0 = 10'($urandom); iRes_Cnt0 = 8'($urandom);
        end
        if (rv[1]) begin
            iRes_X1 = 10'(q1[0].x); iRes_Y1 = 10'(q1[0].y); iRes_Cnt1 = cnt_of(q1[0].x, q1[0].y);
        end else begin
            iRes_X1 = 10'($urandom); iRes_Y1 = 10'($urandom); iRes_Cnt1 = 8'($urandom);
        end
        iJob_Ready = jr;
        iRes_Valid = rv;
        iStart     = start;
        #1;
        busy_e = (phase == 1) && (cyc != done_at);
        done_e = (phase == 1) && (cyc == done_at);
        ejv = (busy_e && next_pix < NPIX && outst < MO) ? rr_pick(jr, job_fav) : 2'b00;
        err = busy_e ? rr_pick(rv, res_fav) : 2'b00;
        chk("job_valid", oJob_Valid, ejv);
        if (ejv != 2'b00) begin
            chk("job_x", oJob_X, next_pix % H);
            chk("job_y", oJob_Y, next_pix / H);
        end
        chk("res_ready", oRes_Ready, err);
        chk("fb_we", oFB_WE, exp_we);
        if (exp_we) begin
            chk("fb_addr", oFB_Addr, exp_addr);
            chk("fb_data", oFB_Data, exp_data);
        end
        chk("busy", oBusy, busy_e);
        chk("done", oDone, done_e);

        if (busy_e) busy_cycles++;
        if (oDone === 1'b1) done_seen++;
        exp_we = 1'b0;
        if (err != 2'b00) begin
            k = err[1] ? 1 : 0;
            if (k == 0) j = q0.pop_front(); else j = q1.pop_front();
            exp_we   = 1'b1;
            exp_addr = j.y * H + j.x;
            exp_data = cnt_of(j.x, j.y);
            written[exp_addr] = 1'b1;
            res_fav = 1 - k;
            outst--;
            nres++;
            if (nres == NPIX) done_at = cyc + 3;
        end
        if (ejv != 2'b00) begin
            k = ejv[1] ? 1 : 0;
            j.x = next_pix % H;
            j.y = next_pix / H;
            j.due = cyc + int'($urandom_range(lmin, lmax));
            if (k == 0) q0.push_back(j); else q1.push_back(j);
            job_fav = 1 - k;
            jobs_k[k]++;
            next_pix++;
            outst++;
        end
        if (done_e) begin
            phase = 0;
        end else if (phase == 0 && start) begin
            phase = 1; next_pix = 0; outst = 0; nres = 0; done_at = -1;
        end
        cyc++;
    endtask

    task automatic run_frame(input int rm, input int lo, input int hi, input bit poke);
        int guard, nw, exp_fc;
        rmode = rm; lmin = lo; lmax = hi; salt = int'($urandom_range(0, 255));
        jobs_k[0] = 0; jobs_k[1] = 0; busy_cycles = 0; done_seen = 0;
        foreach (written[i]) written[i] = 1'b0;
        step(1'b1);
        guard = 0;
        while (phase != 0 && guard < 500) begin
            step(poke && guard == 4);
            guard++;
        end
        chk("frame_timeout", guard < 500, 1);
        step(1'b0);
        nw = 0;
        foreach (written[i]) if (written[i]) nw++;
        chk("done_count", done_seen, 1);
        chk("fb_coverage", nw, NPIX);
`ifdef MANDEL_SCHED_PERF_EN
        exp_fc = busy_cycles;
`else
        exp_fc = 0;
`endif
        chk("frame_cycles", oFrame_Cycles, exp_fc);
    endtask

    initial begin
        int guard;
        vectors = 0; miscompares = 0; cyc = 0; rmode = 0; lmin = 3; lmax = 3; salt = 0;
        busy_cycles = 0; done_seen = 0; jobs_k[0] = 0; jobs_k[1] = 0;
        model_reset();
        iRST_N = 1'b0; iStart = 1'b1; iJob_Ready = 2'b11; iRes_Valid = 2'b11;
        iRes_X0 = 10'd1; iRes_Y0 = 10'd1; iRes_Cnt0 = 8'h55;
        iRes_X1 = 10'd2; iRes_Y1 = 10'd1; iRes_Cnt1 = 8'hAA;
        repeat (2) @(negedge iCLK);
        #1 chk_reset_outputs();
        iStart = 1'b0;
        iRST_N = 1'b1;
        step(1'b0);
        step(1'b0);

        // Both cores always ready, 3-cycle latency: strict alternation.
        run_frame(0, 3, 3, 1'b0);
        chk("alt_core0_jobs", jobs_k[0], 4);
        chk("alt_core1_jobs", jobs_k[1], 4);

        // Only core 0 ready: every job to core 0, stalling at the outstanding limit.
        run_frame(1, 3, 3, 1'b0);
        chk("c0only_core0_jobs", jobs_k[0], NPIX);
        chk("c0only_core1_jobs", jobs_k[1], 0);

        // Random readiness and latency, with an iStart pulse during SCAN.
        run_frame(2, 1, 5, 1'b1);

        // Abort a frame after three jobs with an asynchronous reset.
        rmode = 0; lmin = 3; lmax = 3; done_seen = 0;
        step(1'b1);
        guard = 0;
        while (next_pix < 3 && guard < 100) begin
            step(1'b0);
            guard++;
        end
        @(posedge iCLK);
        #1;
        chk("abort_busy", oBusy, 1);
        chk("abort_job_x", oJob_X, 3);
        iRST_N = 1'b0;
        #1 chk_reset_outputs();
        model_reset();
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        cyc += 3;
        repeat (6) step(1'b0);
        chk("abort_no_done", done_seen, 0);
        q0.delete();
        q1.delete();
        run_frame(2, 1, 4, 1'b0);

        for (int f = 0; f < 6; f++) begin
            run_frame(2, 1, 1 + f, 1'b0);
        end
        run_frame(0, 1, 1, 1'b0);
        run_frame(0, 1, 6, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mandel_job_sched.md
MANDEL_JOB_SCHED -- requirements
Module: mandel_job_sched

Interface
REQ-001 SHALL have parameter H_RES, default 640: pixels per line.
REQ-002 SHALL have parameter V_RES, default 480: lines per frame.
REQ-003 SHALL have parameter MAX_OUT, default 8, range 1..15: maximum jobs outstanding across both cores.
REQ-004 iCLK  in  1  sole clock; all state updates on rising edge.
REQ-005 iRST_N  in  1  asynchronous, active-low reset.
REQ-006 iStart  in  1  pulse that starts one frame; honoured only in IDLE.
REQ-007 oBusy  out  1  high in SCAN and DRAIN.
REQ-008 oDone  out  1  one-cycle pulse at frame completion.
REQ-009 oJob_X  out  10  pixel X of the pending job.
REQ-010 oJob_Y  out  10  pixel Y of the pending job.
REQ-011 oJob_Valid  out  2  per-core job offer; at most one bit high.
REQ-012 iJob_Ready  in  2  per-core job accept.
REQ-013 iRes_Valid  in  2  per-core result offer.
REQ-014 iRes_X0, iRes_Y0, iRes_Cnt0  in  10/10/8  core-0 result: pixel X, pixel Y, iteration count.
REQ-015 iRes_X1, iRes_Y1, iRes_Cnt1  in  10/10/8  core-1 result: pixel X, pixel Y, iteration count.
REQ-016 oRes_Ready  out  2  per-core result accept; at most one bit high.
REQ-017 oFB_Addr  out  19  framebuffer write address.
REQ-018 oFB_Data  out  8  framebuffer write data (iteration count).
REQ-019 oFB_WE  out  1  framebuffer write strobe; the framebuffer always accepts.
REQ-020 oFrame_Cycles  out  24  frame duration in cycles (see Configuration).

Function
REQ-021 SHALL implement the FSM IDLE->SCAN->DRAIN->DONE->IDLE.
REQ-022 IDLE: iStart=1 -> SCAN; pixel counters x=y=0; outstanding count=0.
REQ-023 SCAN: job (x,y) pending whenever outstanding<MAX_OUT; oJob_X/oJob_Y driven from x/y.
REQ-024 Job target: round-robin between cores with iJob_Ready=1; oJob_Valid[k]=pending AND grant[k]. Valid may depend combinationally on ready.
REQ-025 Job handshake: oJob_Valid[k]&iJob_Ready[k]; at most one per cycle. After a job to core k, the job pointer favours core 1-k.
REQ-026 On job handshake: x<=x+1; at x=H_RES-1, x<=0 and y<=y+1. Handshake on (H_RES-1, V_RES-1) -> DRAIN, no further jobs.
REQ-027 Result arbitration: round-robin between iRes_Valid bits, one grant per cycle; oRes_Ready[k]=grant[k], combinational. After a grant to k, priority passes to 1-k.
REQ-028 Result handshake: oFB_WE=1 next cycle; oFB_Addr=Y*H_RES+X (19-bit, no truncation for defaults); oFB_Data=Cnt. Latency exactly 1 cycle.
REQ-029 Results accepted in SCAN and DRAIN only; oRes_Ready=0 in IDLE and DONE.
REQ-030 Outstanding count (4-bit): +1 on job handshake, -1 on result handshake, unchanged when both occur in one cycle; never exceeds MAX_OUT.
REQ-031 DRAIN: outstanding=0 and no write in flight -> DONE.
REQ-032 DONE: oDone=1 for exactly one cycle, then IDLE.
REQ-033 iStart outside IDLE SHALL be ignored.
REQ-034 Both cores ready and both results valid in the same cycle: one job and one result SHALL both complete, each per its own pointer.

Reset
REQ-035 iRST_N=0 asynchronously SHALL force IDLE; x, y, outstanding count and both RR pointers (favour core 0) =0.
REQ-036 During reset, oJob_Valid, oRes_Ready, oFB_WE, oDone and oBusy SHALL be 0; oJob_X, oJob_Y, oFB_Addr and oFB_Data SHALL be 0.
REQ-037 Reset mid-frame SHALL abandon the frame; no oDone; results arriving later are not accepted until the next SCAN.

Configuration
REQ-038 MANDEL_SCHED_PERF_EN defined: 24-bit counter cleared on the IDLE->SCAN transition, incremented each cycle in SCAN/DRAIN, saturating at 0xFFFFFF; value held on oFrame_Cycles until the next start; reset to 0.
REQ-039 MANDEL_SCHED_PERF_EN undefined: oFrame_Cycles tied to 0; no counter logic.

Verification (H_RES=4, V_RES=2, MAX_OUT=2 unless stated)
REQ-040 Both cores always ready, results returned 3 cycles after job -> jobs alternate core0/core1 in raster order (0,0)..(3,1); 8 writes at addresses 0..7; one oDone; oBusy low afterwards.
REQ-041 iJob_Ready=2'b01 only -> all 8 jobs go to core 0; dispatch stalls whenever outstanding=2.
REQ-042 iRes_Valid=2'b11 held, X/Y/Cnt fixed -> oRes_Ready alternates 01,10,01; oFB_Data alternates Cnt0/Cnt1 with 1-cycle latency.
REQ-043 Job and result handshakes in the same cycle with outstanding=2 -> count stays 2 and dispatch continues.
REQ-044 Reset asserted after 3 jobs; iStart re-pulsed -> job restarts at (0,0); no oDone from the aborted frame.
REQ-045 PERF_EN defined, fixed result latency of 3 cycles -> oFrame_Cycles equals the SCAN+DRAIN cycle count measured by the bench; iStart pulsed during SCAN is ignored.
